// File: rtl/ppc_bus_bridge_if.sv
`default_nettype none
// ============================================================================
// Module   : ppc_bus_bridge_if
// Purpose  : CPU 60x/MPX-style bus and host-bridge request/response port
//            bundled for the ppc_bus_bridge. slave = bridge view,
//            master = environment (CPU + host) view.
// Revision : 1.0 - initial release
// ============================================================================
interface ppc_bus_bridge_if #(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 64,
   parameter int BURST_BEATS = 4
) ();
   localparam int c_BW = $clog2(BURST_BEATS) + 1;

   // CPU side
   logic              cpu_ts;
   logic [ADDR_W-1:0] cpu_addr;
   logic              cpu_rd;
   logic              cpu_burst;
   logic              cpu_aack;
   logic              cpu_ta;
   logic              cpu_tea;
   logic [DATA_W-1:0] cpu_wdata;
   logic [DATA_W-1:0] cpu_rdata;

   // Host side
   logic              host_req_valid;
   logic              host_req_ready;
   logic [ADDR_W-1:0] host_req_addr;
   logic              host_req_rd;
   logic [c_BW-1:0]   host_req_beats;
   logic              host_wvalid;
   logic              host_wready;
   logic [DATA_W-1:0] host_wdata;
   logic              host_rvalid;
   logic              host_rready;
   logic [DATA_W-1:0] host_rdata;

   // Status
   logic              busy;

   modport slave (
      input  cpu_ts, cpu_addr, cpu_rd, cpu_burst, cpu_wdata,
      input  host_req_ready, host_wready, host_rvalid, host_rdata,
      output cpu_aack, cpu_ta, cpu_tea, cpu_rdata,
      output host_req_valid, host_req_addr, host_req_rd, host_req_beats,
      output host_wvalid, host_wdata, host_rready, busy
   );

   modport master (
      output cpu_ts, cpu_addr, cpu_rd, cpu_burst, cpu_wdata,
      output host_req_ready, host_wready, host_rvalid, host_rdata,
      input  cpu_aack, cpu_ta, cpu_tea, cpu_rdata,
      input  host_req_valid, host_req_addr, host_req_rd, host_req_beats,
      input  host_wvalid, host_wdata, host_rready, busy
   );
endinterface
`default_nettype wire

// File: rtl/ppc_bus_bridge.sv
`default_nettype none
// ============================================================================
// Module   : ppc_bus_bridge
// Purpose  : Pipelined CPU-bus to host-bridge bridge. Address tenures are
//            queued (up to PIPE_DEPTH outstanding); data tenures run in order
//            as single or burst transfers; a watchdog converts host stalls
//            into a transfer error.
// Revision : 1.0 - initial release
// ============================================================================
module ppc_bus_bridge #(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 64,
   parameter int BURST_BEATS = 4,
   parameter int PIPE_DEPTH  = 2,
   parameter int TIMEOUT     = 255
) (
   input  logic             clk,
   input  logic             rst_n,
   ppc_bus_bridge_if.slave  bus
);
   localparam int c_BW = $clog2(BURST_BEATS) + 1;
   localparam int c_PW = (PIPE_DEPTH > 1) ? $clog2(PIPE_DEPTH) : 1;
   localparam int c_CW = $clog2(PIPE_DEPTH + 1);
   localparam int c_WW = $clog2(TIMEOUT + 1);

   localparam logic [c_BW-1:0] c_BEATS_BURST = c_BW'(BURST_BEATS);
   localparam logic [c_BW-1:0] c_BEATS_ONE   = c_BW'(1);
   localparam logic [c_CW-1:0] c_DEPTH       = c_CW'(PIPE_DEPTH);
   localparam logic [c_PW-1:0] c_PTR_LAST    = c_PW'(PIPE_DEPTH - 1);
   localparam logic [c_WW-1:0] c_WD_LIMIT    = c_WW'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_REQ   = 3'd1,
      S_WDATA = 3'd2,
      S_RDATA = 3'd3,
      S_ERR   = 3'd4
   } state_t;

   state_t            r_state;

   // Address queue
   logic [ADDR_W-1:0] r_q_addr  [PIPE_DEPTH];
   logic              r_q_rd    [PIPE_DEPTH];
   logic              r_q_burst [PIPE_DEPTH];
   logic [c_PW-1:0]   r_wr_ptr;
   logic [c_PW-1:0]   r_rd_ptr;
   logic [c_CW-1:0]   r_count;

   logic              r_aack;
   logic              r_req_valid;
   logic              r_rd_ta;
   logic              r_tea;
   logic [DATA_W-1:0] r_rdata;
   logic [c_BW-1:0]   r_beats;
   logic [c_WW-1:0]   r_wd;      // cycles since entry or last handshake

   logic              w_push;
   logic              w_pop;
   logic              w_req_hs;
   logic              w_wr_st;
   logic              w_rd_st;
   logic              w_rready;
   logic              w_w_hs;
   logic              w_r_hs;
   logic              w_hs;
   logic              w_ta;
   logic              w_timeout;
   logic [ADDR_W-1:0] w_head_addr;
   logic              w_head_rd;
   logic              w_head_burst;

   function automatic logic [c_PW-1:0] f_ptr_next(input logic [c_PW-1:0] ptr);
      return (ptr == c_PTR_LAST) ? '0 : ptr + c_PW'(1);
   endfunction

   assign w_head_addr  = r_q_addr[r_rd_ptr];
   assign w_head_rd    = r_q_rd[r_rd_ptr];
   assign w_head_burst = r_q_burst[r_rd_ptr];

   assign w_push    = bus.cpu_ts & r_aack;
   assign w_req_hs  = r_req_valid & bus.host_req_ready;
   assign w_wr_st   = (r_state == S_WDATA);
   assign w_rd_st   = (r_state == S_RDATA);
   // Read beats are accepted only when no TA is pending, giving one beat per 2 cycles
   assign w_rready  = w_rd_st & ~r_rd_ta;
   assign w_w_hs    = w_wr_st & bus.host_wready;
   assign w_r_hs    = w_rready & bus.host_rvalid;
   assign w_hs      = w_req_hs | w_w_hs | w_r_hs;
   assign w_ta      = w_w_hs | r_rd_ta;
   assign w_timeout = ((r_state == S_REQ) | w_wr_st | w_rd_st) & ~w_hs & (r_wd == c_WD_LIMIT);
   // An abandoned request still leaves the queue
   assign w_pop     = w_req_hs | ((r_state == S_REQ) & w_timeout);

   assign bus.cpu_aack       = r_aack;
   assign bus.cpu_ta         = w_ta;
   assign bus.cpu_tea        = r_tea;
   assign bus.cpu_rdata      = r_rdata;
   assign bus.host_req_valid = r_req_valid;
   assign bus.host_req_addr  = r_req_valid ? w_head_addr : '0;
   assign bus.host_req_rd    = r_req_valid & w_head_rd;
   assign bus.host_req_beats = r_req_valid ? (w_head_burst ? c_BEATS_BURST : c_BEATS_ONE) : '0;
   assign bus.host_wvalid    = w_wr_st;
   assign bus.host_wdata     = w_wr_st ? bus.cpu_wdata : '0;
   assign bus.host_rready    = w_rready;
   assign bus.busy           = (r_count != '0) | (r_state != S_IDLE);

   // Address acknowledge: one-cycle pulse when a slot is free (or frees this cycle)
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_aack <= 1'b0;
      end else begin
         r_aack <= bus.cpu_ts & ~r_aack & ((r_count < c_DEPTH) | w_pop);
      end
   end

   // Queue pointers and occupancy
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= f_ptr_next(r_wr_ptr);
         if (w_pop)  r_rd_ptr <= f_ptr_next(r_rd_ptr);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + c_CW'(1);
            2'b01:   r_count <= r_count - c_CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Queue storage: address attributes captured at the address tenure
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_q_addr[r_wr_ptr]  <= bus.cpu_addr;
         r_q_rd[r_wr_ptr]    <= bus.cpu_rd;
         r_q_burst[r_wr_ptr] <= bus.cpu_burst;
      end
   end

   // Data-tenure FSM with beat counter, read capture and watchdog
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_req_valid <= 1'b0;
         r_rd_ta     <= 1'b0;
         r_tea       <= 1'b0;
         r_rdata     <= '0;
         r_beats     <= '0;
         r_wd        <= '0;
      end else begin
         r_tea   <= 1'b0;
         r_rd_ta <= w_r_hs;
         if (w_r_hs) r_rdata <= bus.host_rdata;
         if (w_ta)   r_beats <= r_beats - c_BW'(1);

         if (w_hs)
            r_wd <= c_WW'(1);
         else if ((r_state == S_REQ) | w_wr_st | w_rd_st)
            r_wd <= r_wd + c_WW'(1);

         case (r_state)
            S_IDLE: begin
               if (r_count != '0) begin
                  r_state     <= S_REQ;
                  r_req_valid <= 1'b1;
                  r_wd        <= c_WW'(1);
               end
            end
            S_REQ: begin
               if (w_req_hs) begin
                  r_req_valid <= 1'b0;
                  r_beats     <= w_head_burst ? c_BEATS_BURST : c_BEATS_ONE;
                  r_state     <= w_head_rd ? S_RDATA : S_WDATA;
               end else if (w_timeout) begin
                  r_req_valid <= 1'b0;
                  r_tea       <= 1'b1;
                  r_state     <= S_ERR;
               end
            end
            S_WDATA, S_RDATA: begin
               if (w_ta && (r_beats == c_BEATS_ONE)) begin
                  r_state <= S_IDLE;
               end else if (w_timeout) begin
                  r_tea   <= 1'b1;
                  r_state <= S_ERR;
               end
            end
            S_ERR: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_ppc_bus_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_ppc_bus_bridge
// Purpose  : Directed self-checking bench for ppc_bus_bridge
//            (PIPE_DEPTH=2, TIMEOUT=8, BURST_BEATS=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ppc_bus_bridge;
   localparam int ADDR_W      = 32;
   localparam int DATA_W      = 64;
   localparam int BURST_BEATS = 4;
   localparam int PIPE_DEPTH  = 2;
   localparam int TIMEOUT     = 8;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   ppc_bus_bridge_if #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_BEATS(BURST_BEATS)
   ) bus ();

   ppc_bus_bridge #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_BEATS(BURST_BEATS),
      .PIPE_DEPTH(PIPE_DEPTH), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Present one address tenure and check the aack timing; queue must have room
   task automatic issue(input logic [31:0] a, input logic rd, input logic burst, input string tag);
      @(negedge clk);
      bus.cpu_ts = 1'b1; bus.cpu_addr = a; bus.cpu_rd = rd; bus.cpu_burst = burst;
      #1; check({tag, "_aack_early"}, 64'(bus.cpu_aack), 64'd0);
      @(negedge clk);
      #1; check({tag, "_aack"}, 64'(bus.cpu_aack), 64'd1);
      @(negedge clk);
      bus.cpu_ts = 1'b0;
      #1; check({tag, "_aack_gap"}, 64'(bus.cpu_aack), 64'd0);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_aack"},  64'(bus.cpu_aack),       64'd0);
      check({tag, "_ta"},    64'(bus.cpu_ta),         64'd0);
      check({tag, "_tea"},   64'(bus.cpu_tea),        64'd0);
      check({tag, "_rdata"}, bus.cpu_rdata,           64'd0);
      check({tag, "_reqv"},  64'(bus.host_req_valid), 64'd0);
      check({tag, "_reqa"},  64'(bus.host_req_addr),  64'd0);
      check({tag, "_beats"}, 64'(bus.host_req_beats), 64'd0);
      check({tag, "_wvld"},  64'(bus.host_wvalid),    64'd0);
      check({tag, "_wdata"}, bus.host_wdata,          64'd0);
      check({tag, "_rrdy"},  64'(bus.host_rready),    64'd0);
      check({tag, "_busy"},  64'(bus.busy),           64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL tb_watchdog: got no finish expected finish");
      $fatal(1, "bench time limit");
   end

   initial begin
      logic [31:0] rec [4];
      int          nrec;
      int          n_stray;
      int          nta;
      int          beat;
      logic [0:6]  pat;

      bus.cpu_ts = 0; bus.cpu_addr = '0; bus.cpu_rd = 0; bus.cpu_burst = 0; bus.cpu_wdata = '0;
      bus.host_req_ready = 0; bus.host_wready = 0; bus.host_rvalid = 0; bus.host_rdata = '0;

      // Reset state
      repeat (3) @(negedge clk);
      #1; check_all_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Single write
      bus.host_req_ready = 1; bus.host_wready = 1;
      bus.cpu_wdata = 64'hA5A5_A5A5_A5A5_A5A5;
      issue(32'h1000, 1'b0, 1'b0, "wr1");
      @(negedge clk); #1;
      check("wr1_reqv",  64'(bus.host_req_valid), 64'd1);
      check("wr1_addr",  64'(bus.host_req_addr),  64'h1000);
      check("wr1_beats", 64'(bus.host_req_beats), 64'd1);
      check("wr1_rd",    64'(bus.host_req_rd),    64'd0);
      @(negedge clk); #1;
      check("wr1_wvld",  64'(bus.host_wvalid),    64'd1);
      check("wr1_wdata", bus.host_wdata,          64'hA5A5_A5A5_A5A5_A5A5);
      check("wr1_ta",    64'(bus.cpu_ta),         64'd1);
      @(negedge clk); #1;
      check("wr1_ta_end", 64'(bus.cpu_ta),        64'd0);
      check("wr1_busy",   64'(bus.busy),          64'd0);

      // Burst read, host beats 1..4
      issue(32'h2000, 1'b1, 1'b1, "brd");
      @(negedge clk); #1;
      check("brd_addr",  64'(bus.host_req_addr),  64'h2000);
      check("brd_beats", 64'(bus.host_req_beats), 64'd4);
      check("brd_rd",    64'(bus.host_req_rd),    64'd1);
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         bus.host_rvalid = 1; bus.host_rdata = 64'(k);
         #1;
         check("brd_rready", 64'(bus.host_rready), 64'd1);
         check("brd_ta_gap", 64'(bus.cpu_ta),      64'd0);
         @(negedge clk); #1;
         check("brd_ta",     64'(bus.cpu_ta),      64'd1);
         check("brd_rdata",  bus.cpu_rdata,        64'(k));
         check("brd_rr_ta",  64'(bus.host_rready), 64'd0);
      end
      @(negedge clk);
      bus.host_rvalid = 0;
      #1;
      check("brd_ta_end", 64'(bus.cpu_ta), 64'd0);
      check("brd_busy",   64'(bus.busy),   64'd0);
      check("brd_hold",   bus.cpu_rdata,   64'd4);

      // Pipelining with host request stalled
      bus.host_req_ready = 0; bus.host_wready = 0;
      @(negedge clk);
      bus.cpu_ts = 1; bus.cpu_addr = 32'h3000; bus.cpu_rd = 0; bus.cpu_burst = 0;
      #1;
      @(negedge clk); #1;
      check("p_aack_a", 64'(bus.cpu_aack), 64'd1);
      @(negedge clk);
      bus.cpu_addr = 32'h3008;
      #1; check("p_aack_gap", 64'(bus.cpu_aack), 64'd0);
      @(negedge clk); #1;
      check("p_aack_b", 64'(bus.cpu_aack), 64'd1);
      @(negedge clk);
      bus.cpu_addr = 32'h3010; bus.cpu_rd = 1;
      #1; check("p_full0", 64'(bus.cpu_aack), 64'd0);
      @(negedge clk); #1;
      check("p_full1", 64'(bus.cpu_aack),       64'd0);
      check("p_reqv",  64'(bus.host_req_valid), 64'd1);
      @(negedge clk);
      bus.host_req_ready = 1;
      #1;
      check("p_full2",  64'(bus.cpu_aack),      64'd0);
      check("p_hs_a",   64'(bus.host_req_addr), 64'h3000);
      @(negedge clk); #1;
      check("p_aack_c", 64'(bus.cpu_aack), 64'd1);
      @(negedge clk);
      bus.cpu_ts = 0; bus.host_wready = 1; bus.host_rvalid = 1; bus.host_rdata = 64'hC0DE;
      #1;
      nrec = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk); #1;
         if (bus.host_req_valid && bus.host_req_ready && nrec < 4) begin
            rec[nrec] = bus.host_req_addr;
            nrec++;
         end
         if (!bus.busy) break;
      end
      bus.host_rvalid = 0;
      check("p_nreq", 64'(nrec), 64'd2);
      check("p_2nd",  64'(rec[0]), 64'h3008);
      check("p_3rd",  64'(rec[1]), 64'h3010);
      check("p_idle", 64'(bus.busy), 64'd0);

      // Watchdog timeout on a stalled burst read, then a queued write
      bus.host_req_ready = 1; bus.host_wready = 1; bus.host_rvalid = 0;
      @(negedge clk);
      bus.cpu_ts = 1; bus.cpu_addr = 32'h4000; bus.cpu_rd = 1; bus.cpu_burst = 1;
      #1;
      @(negedge clk); #1;
      check("to_aack_a", 64'(bus.cpu_aack), 64'd1);
      @(negedge clk);
      bus.cpu_addr = 32'h5000; bus.cpu_rd = 0; bus.cpu_burst = 0; bus.cpu_wdata = 64'h1234;
      #1;
      @(negedge clk); #1;
      check("to_aack_b", 64'(bus.cpu_aack),      64'd1);
      check("to_req_a",  64'(bus.host_req_addr), 64'h4000);
      @(negedge clk);
      bus.cpu_ts = 0; bus.host_rvalid = 1; bus.host_rdata = 64'h11;
      #1; check("to_rready", 64'(bus.host_rready), 64'd1);
      @(negedge clk);
      bus.host_rvalid = 0;
      #1;
      check("to_ta1",    64'(bus.cpu_ta), 64'd1);
      check("to_rdata",  bus.cpu_rdata,   64'h11);
      n_stray = 0;
      repeat (6) begin
         @(negedge clk); #1;
         if (bus.cpu_ta || bus.cpu_tea) n_stray++;
      end
      check("to_quiet", 64'(n_stray), 64'd0);
      @(negedge clk); #1;
      check("to_tea",      64'(bus.cpu_tea),     64'd1);
      check("to_tea_ta",   64'(bus.cpu_ta),      64'd0);
      check("to_err_rrdy", 64'(bus.host_rready), 64'd0);
      @(negedge clk); #1;
      check("to_tea_once", 64'(bus.cpu_tea), 64'd0);
      @(negedge clk); #1;
      check("to_next_reqv", 64'(bus.host_req_valid), 64'd1);
      check("to_next_addr", 64'(bus.host_req_addr),  64'h5000);
      @(negedge clk); #1;
      check("to_next_ta",    64'(bus.cpu_ta),  64'd1);
      check("to_next_wdata", bus.host_wdata,   64'h1234);
      @(negedge clk); #1;
      check("to_idle", 64'(bus.busy), 64'd0);

      // Write burst with host backpressure
      bus.host_req_ready = 1; bus.host_wready = 0;
      pat = 7'b1001101;
      issue(32'h6000, 1'b0, 1'b1, "bp");
      @(negedge clk); #1;
      check("bp_beats", 64'(bus.host_req_beats), 64'd4);
      beat = 0; nta = 0;
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         bus.host_wready = pat[i];
         bus.cpu_wdata = 64'h6000_0000_0000_0100 + 64'(beat);
         #1;
         check("bp_ta",    64'(bus.cpu_ta), 64'(pat[i]));
         check("bp_wdata", bus.host_wdata,  64'h6000_0000_0000_0100 + 64'(beat));
         if (bus.cpu_ta) nta++;
         if (pat[i]) beat++;
      end
      check("bp_ntas", 64'(nta), 64'd4);
      @(negedge clk);
      bus.host_wready = 0;
      #1;
      check("bp_wvld_end", 64'(bus.host_wvalid), 64'd0);
      check("bp_busy",     64'(bus.busy),        64'd0);

      // Reset in the middle of a burst read
      bus.host_wready = 1;
      issue(32'h7000, 1'b1, 1'b1, "mr");
      @(negedge clk); #1;
      for (int k = 1; k <= 2; k++) begin
         @(negedge clk);
         bus.host_rvalid = 1; bus.host_rdata = 64'h70 + 64'(k);
         #1;
         @(negedge clk); #1;
         check("mr_ta",    64'(bus.cpu_ta), 64'd1);
         check("mr_rdata", bus.cpu_rdata,   64'h70 + 64'(k));
      end
      @(negedge clk);
      rst_n = 1'b0; bus.host_rvalid = 0;
      #1;
      @(negedge clk);
      rst_n = 1'b1;
      #1; check_all_zero("mr_rst");
      issue(32'h8000, 1'b0, 1'b0, "post");
      @(negedge clk); #1;
      check("post_addr", 64'(bus.host_req_addr), 64'h8000);
      @(negedge clk); #1;
      check("post_ta",   64'(bus.cpu_ta), 64'd1);
      @(negedge clk); #1;
      check("post_busy", 64'(bus.busy), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/ppc_bus_bridge.md
Name: ppc_bus_bridge

Overview:
Parametrised bridge between the CPU 60x/MPX-style processor bus and the host-bridge request/response port. It accepts pipelined address tenures into a queue, with up to PIPE_DEPTH outstanding addresses. It then runs data tenures in order as single or burst transfers, with per-beat handshakes on both sides. A watchdog turns host stalls into a transfer error. It succeeds the fixed-width, single-outstanding bridge in the CPU-to-host-bridge subsystem.

Parameters:
ADDR_W, 32, address width
DATA_W, 64, data beat width
BURST_BEATS, 4, beats in a burst transfer (power of 2, >=2)
PIPE_DEPTH, 2, address-queue entries (>=1)
TIMEOUT, 255, idle cycles in a data tenure before error (>=2)

Ports:
clk  in  1  single clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
cpu_ts  in  1  transfer start; held high with address/attributes until cpu_aack
cpu_addr  in  ADDR_W  transfer address
cpu_rd  in  1  1=read, 0=write
cpu_burst  in  1  1=BURST_BEATS beats, 0=single beat
cpu_aack  out  1  address acknowledge, one-cycle pulse
cpu_ta  out  1  data beat acknowledge
cpu_tea  out  1  transfer error, one-cycle pulse
cpu_wdata  in  DATA_W  write beat, held until cpu_ta
cpu_rdata  out  DATA_W  read beat, valid while cpu_ta=1
host_req_valid  out  1  request valid
host_req_ready  in  1  request accepted
host_req_addr  out  ADDR_W  request address
host_req_rd  out  1  request direction
host_req_beats  out  $clog2(BURST_BEATS)+1  beat count (1 or BURST_BEATS)
host_wvalid  out  1  write beat valid
host_wready  in  1  write beat accepted
host_wdata  out  DATA_W  write beat
host_rvalid  in  1  read beat valid
host_rready  out  1  read beat accepted
busy  out  1  queue non-empty or data FSM not IDLE

Behaviour:
- Reset: all outputs 0 (cpu_rdata = 0). Queue is emptied, FSM goes to IDLE, counters clear. This applies in any state, including mid-burst; an in-flight transfer is dropped without TA/TEA.
- Address tenure:
  - If cpu_ts=1, cpu_aack=0, and queue count < PIPE_DEPTH, then cpu_aack=1 in the next cycle.
  - The address is accepted (pushed: addr, rd, burst) in the cycle where cpu_ts & cpu_aack.
  - cpu_aack is never high in two consecutive cycles.
  - If the queue is full, cpu_aack is withheld until a pop; a pop and a push in the same cycle are allowed.
- Data FSM states: IDLE, REQ, WDATA, RDATA, ERR.
  - IDLE: if the queue is non-empty, go to REQ. The head entry drives host_req_* while host_req_valid=1.
  - REQ: on host_req_valid & host_req_ready, pop the head, load the beat counter (1 or BURST_BEATS), and go to RDATA if rd, else WDATA.
  - WDATA:
    - host_wvalid=1 and host_wdata=cpu_wdata, combinational.
    - cpu_ta = host_wready, combinational.
    - Each ta decrements the counter; the last beat goes to IDLE.
  - RDATA:
    - host_rready=1 except in the cycle cpu_ta is high.
    - On host_rvalid & host_rready, capture host_rdata into cpu_rdata; cpu_ta=1 the next cycle.
    - Max one read beat per 2 cycles.
    - After the last beat's ta, go to IDLE.
  - Back-to-back transfers: IDLE->REQ the cycle after completion. There is no dead cycle on the host side beyond this.
- Watchdog:
  - The counter clears on entry to REQ/WDATA/RDATA and on any handshake.
  - It increments while stalled. At TIMEOUT it goes to ERR.
  - ERR: cpu_tea=1 for one cycle, and all host valid/ready signals are 0. The transfer is abandoned (the entry is popped if still in REQ), then the FSM goes to IDLE.
  - Remaining beats are not acknowledged.
- cpu_ta and cpu_tea are never high together. cpu_rdata holds its last value when ta=0.
- The beat counter is width $clog2(BURST_BEATS)+1 and has no wrap-around; completion is counter==1 with ta.

Test Plan:
- Single write: addr 0x1000, wdata 0xA5A5..., host ready tied 1 -> aack 1 cycle after ts; host_req_beats=1; one cpu_ta; host_wdata matches; busy falls afterwards.
- Burst read: addr 0x2000, host returns beats 1,2,3,4 back-to-back -> exactly 4 cpu_ta pulses, cpu_rdata=1,2,3,4 in order, each 1 cycle after the host handshake.
- Pipelining, PIPE_DEPTH=2, host_req_ready=0: issue 3 ts -> first two aack'd; third aack withheld until the first REQ handshake, then aack'd next cycle; transfers complete in issue order.
- Timeout, TIMEOUT=8: burst read, host gives 1 beat then stalls -> 1 ta, then cpu_tea exactly 8 cycles after the last handshake, no further ta; next queued write completes normally.
- Write backpressure: host_wready toggles 1,0,0,1,1,0,1 on a burst -> ta mirrors wready, 4 ta total, cpu_wdata held until each ta.
- Reset mid-burst: rst_n=0 for 1 cycle after 2 read beats -> all outputs 0 next cycle, busy=0, new ts accepted normally.
